fsm_abcd_decoder: RTL and testbench

Receive-side decoder for the `fsm_abcd` pulse line. The encoder turns an N-cycle high run on its input (N ≥ 1) into an (N+1)-cycle high run on `y`, followed by at least one forced low cycle. This block samples that line, recovers N for each run and flags malformed or over-long runs. It delivers each N through a one-entry valid/ready output slot to the downstream consumer.

---
 rtl/fsm_abcd_pkg.sv | 14 +
 rtl/fsm_abcd_len_slot.sv | 45 ++++
 rtl/fsm_abcd_decoder.sv | 105 ++++++++++
 tb/tb_fsm_abcd_decoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_abcd_pkg.sv
// Shared definitions for the fsm_abcd pulse-line decoder family.
// Holds the decoder state encoding and the default recovered-length width.
package fsm_abcd_pkg;

  localparam int CNT_W_DEFAULT = 8;

  // 2'b11 is unused and steered back to IDLE by the decoder.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    SAT  = 2'b10
  } state_t;

endpackage

// File: rtl/fsm_abcd_len_slot.sv
// One-entry valid/ready holding register with a registered overrun pulse.
// An offer while full and not being drained is dropped and flagged.
module fsm_abcd_len_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_offer,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_overrun
);

  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_overrun;

  // A drain and a new offer in the same cycle hand over without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_offer) begin
        if (!r_valid || i_ready) begin
          r_data  <= i_data;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/fsm_abcd_decoder.sv
// Receive-side decoder for the fsm_abcd pulse line: recovers N from each
// (N+1)-cycle high run and flags short or over-long runs.
module fsm_abcd_decoder
  import fsm_abcd_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [CNT_W-1:0] len_out,
  output logic             len_valid,
  input  logic             len_ready,
  output logic             err_short,
  output logic             err_ovf,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_short;
  logic             r_err_ovf;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_offer;
  logic             w_err_short_nxt;
  logic             w_err_ovf_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_err_short <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err_short <= w_err_short_nxt;
      r_err_ovf   <= w_err_ovf_nxt;
    end
  end

  // The first high cycle is the encoder's extra cycle, so cnt starts at 0.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_offer         = 1'b0;
    w_err_short_nxt = 1'b0;
    w_err_ovf_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (din) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (din) begin
          if (r_cnt == CNT_MAX) begin
            w_state_nxt = SAT;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
          if (r_cnt == '0) begin
            w_err_short_nxt = 1'b1;
          end else begin
            w_offer = 1'b1;
          end
        end
      end
      SAT: begin
        if (!din) begin
          w_state_nxt   = IDLE;
          w_err_ovf_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  fsm_abcd_len_slot #(
    .W (CNT_W)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst),
    .i_offer   (w_offer),
    .i_data    (r_cnt),
    .i_ready   (len_ready),
    .o_data    (len_out),
    .o_valid   (len_valid),
    .o_overrun (overrun)
  );

  assign err_short = r_err_short;
  assign err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_fsm_abcd_decoder.sv
// Directed self-checking bench for fsm_abcd_decoder at CNT_W=4.
// Outputs are packed as {len_valid, len_out, err_short, err_ovf, overrun}.
module tb_fsm_abcd_decoder;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             din;
  logic             len_ready;
  logic [CNT_W-1:0] len_out;
  logic             len_valid;
  logic             err_short;
  logic             err_ovf;
  logic             overrun;

  logic [7:0] obs;
  logic [7:0] exp8;
  logic [3:0] exp4;
  int compared;
  int mismatched;

  fsm_abcd_decoder #(
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .len_out   (len_out),
    .len_valid (len_valid),
    .len_ready (len_ready),
    .err_short (err_short),
    .err_ovf   (err_ovf),
    .overrun   (overrun)
  );

  assign obs = {len_valid, len_out, err_short, err_ovf, overrun};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; din = 1'b1; len_ready = 1'b0;
    repeat (3) begin
      cyc();
      exp8 = 8'b0; compared++;
      if (obs !== exp8) begin
        mismatched++;
        $display("[TB] FAIL reset_hold: got %b want %b", obs, exp8);
      end
    end
    din = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      cyc();
      exp8 = 8'b0; compared++;
      if (obs !== exp8) begin
        mismatched++;
        $display("[TB] FAIL reset_idle: got %b want %b", obs, exp8);
      end
    end
  endtask

  task automatic test_basic();
    len_ready = 1'b1;
    din = 1'b1;
    repeat (4) begin
      cyc();
      exp8 = 8'b0; compared++;
      if (obs !== exp8) begin
        mismatched++;
        $display("[TB] FAIL basic_running: got %b want %b", obs, exp8);
      end
    end
    din = 1'b0;
    cyc();
    exp8 = {1'b1, 4'd3, 3'b000}; compared++;
    if (obs !== exp8) begin
      mismatched++;
      $display("[TB] FAIL basic_result: got %b want %b", obs, exp8);
    end
    cyc();
    compared++;
    if (len_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_consumed: got valid=%b want 0", len_valid);
    end
  endtask

  task automatic test_short();
    din = 1'b1;
    cyc();
    din = 1'b0;
    cyc();
    exp4 = 4'b0100; compared++;
    if ({obs[7], obs[2:0]} !== exp4) begin
      mismatched++;
      $display("[TB] FAIL short_pulse: got %b want %b", {obs[7], obs[2:0]}, exp4);
    end
    cyc();
    exp4 = 4'b0000; compared++;
    if ({obs[7], obs[2:0]} !== exp4) begin
      mismatched++;
      $display("[TB] FAIL short_after: got %b want %b", {obs[7], obs[2:0]}, exp4);
    end
  endtask

  task automatic test_overflow();
    din = 1'b1;
    repeat (17) begin
      cyc();
      exp4 = 4'b0000; compared++;
      if ({obs[7], obs[2:0]} !== exp4) begin
        mismatched++;
        $display("[TB] FAIL ovf_running: got %b want %b", {obs[7], obs[2:0]}, exp4);
      end
    end
    din = 1'b0;
    cyc();
    exp4 = 4'b0010; compared++;
    if ({obs[7], obs[2:0]} !== exp4) begin
      mismatched++;
      $display("[TB] FAIL ovf_pulse: got %b want %b", {obs[7], obs[2:0]}, exp4);
    end
    cyc();
    exp4 = 4'b0000; compared++;
    if ({obs[7], obs[2:0]} !== exp4) begin
      mismatched++;
      $display("[TB] FAIL ovf_after: got %b want %b", {obs[7], obs[2:0]}, exp4);
    end
    din = 1'b1;
    repeat (16) cyc();
    din = 1'b0;
    cyc();
    exp8 = {1'b1, 4'd15, 3'b000}; compared++;
    if (obs !== exp8) begin
      mismatched++;
      $display("[TB] FAIL max_len: got %b want %b", obs, exp8);
    end
    cyc();
    compared++;
    if (len_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL max_consumed: got valid=%b want 0", len_valid);
    end
  endtask

  task automatic test_back_to_back();
    len_ready = 1'b0;
    din = 1'b1;
    repeat (3) cyc();
    din = 1'b0;
    cyc();
    exp8 = {1'b1, 4'd2, 3'b000}; compared++;
    if (obs !== exp8) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got %b want %b", obs, exp8);
    end
    din = 1'b1;
    repeat (6) begin
      cyc();
      exp8 = {1'b1, 4'd2, 3'b000}; compared++;
      if (obs !== exp8) begin
        mismatched++;
        $display("[TB] FAIL b2b_hold: got %b want %b", obs, exp8);
      end
    end
    din = 1'b0;
    cyc();
    exp8 = {1'b1, 4'd2, 3'b001}; compared++;
    if (obs !== exp8) begin
      mismatched++;
      $display("[TB] FAIL b2b_overrun: got %b want %b", obs, exp8);
    end
    din = 1'b1;
    repeat (8) begin
      cyc();
      exp8 = {1'b1, 4'd2, 3'b000}; compared++;
      if (obs !== exp8) begin
        mismatched++;
        $display("[TB] FAIL b2b_third_run: got %b want %b", obs, exp8);
      end
    end
    din = 1'b0;
    len_ready = 1'b1;
    cyc();
    exp8 = {1'b1, 4'd7, 3'b000}; compared++;
    if (obs !== exp8) begin
      mismatched++;
      $display("[TB] FAIL b2b_handover: got %b want %b", obs, exp8);
    end
    cyc();
    compared++;
    if (len_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_drained: got valid=%b want 0", len_valid);
    end
  endtask

  task automatic test_reset_midrun();
    len_ready = 1'b1;
    din = 1'b1;
    repeat (7) cyc();
    rst = 1'b0;
    din = 1'b0;
    #1;
    exp8 = 8'b0; compared++;
    if (obs !== exp8) begin
      mismatched++;
      $display("[TB] FAIL midrun_async: got %b want %b", obs, exp8);
    end
    cyc();
    rst = 1'b1;
    repeat (3) begin
      cyc();
      exp8 = 8'b0; compared++;
      if (obs !== exp8) begin
        mismatched++;
        $display("[TB] FAIL midrun_after: got %b want %b", obs, exp8);
      end
    end
    din = 1'b1;
    repeat (5) cyc();
    din = 1'b0;
    cyc();
    exp8 = {1'b1, 4'd4, 3'b000}; compared++;
    if (obs !== exp8) begin
      mismatched++;
      $display("[TB] FAIL midrun_next: got %b want %b", obs, exp8);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b0;
    din = 1'b0;
    len_ready = 1'b0;
    test_reset();
    test_basic();
    test_short();
    test_overflow();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
